// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one AXI4-Lite master between fetch and data.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AWW  = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]        r_state;
  logic              r_own_dm;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [CNT_W-1:0]  r_starve;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              r_if_err;
  logic              r_dm_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_busy;

  logic w_any_ack;
  logic w_gnt_f;
  logic w_gnt_d;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_unused;

  // an ack cycle gives the requester time to update req/addr
  assign w_any_ack = r_if_ack | r_dm_ack;
  assign w_gnt_f   = ~w_any_ack & if_req &
                     (~dm_req | (r_starve == STARVE_LIM));
  assign w_gnt_d   = ~w_any_ack & dm_req & ~w_gnt_f;

  assign w_aw_hs  = r_awvalid & m_awready;
  assign w_w_hs   = r_wvalid & m_wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;
  assign w_unused = m_rresp[0] ^ m_bresp[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_own_dm   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_starve   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_err   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_f || w_gnt_d) begin
            r_own_dm <= w_gnt_d;
            r_addr   <= w_gnt_d ? dm_addr : if_addr;
            r_wdata  <= dm_wdata;
            r_wstrb  <= dm_wstrb;
            r_busy   <= 1'b1;
            if (w_gnt_d && dm_we) begin
              r_state   <= S_AWW;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
          if (w_gnt_f) begin
            r_starve <= '0;
          end else if (w_gnt_d && if_req && r_starve != STARVE_LIM) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        S_AR: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (m_rvalid) begin
            r_rready <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
            if (r_own_dm) begin
              r_dm_rdata <= m_rdata;
              r_dm_err   <= m_rresp[1];
              r_dm_ack   <= 1'b1;
            end else begin
              r_if_rdata <= m_rdata;
              r_if_err   <= m_rresp[1];
              r_if_ack   <= 1'b1;
            end
          end
        end
        S_AWW: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_B;
          end
        end
        S_B: begin
          if (m_bvalid) begin
            r_bready <= 1'b0;
            r_dm_err <= m_bresp[1];
            r_dm_ack <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign dm_ack    = r_dm_ack;
  assign dm_rdata  = r_dm_rdata;
  assign dm_err    = r_dm_err;
  assign busy      = r_busy;
  assign m_awaddr  = r_addr;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_araddr  = r_addr;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed steps, then random traffic against an
// AXI4-Lite slave with stalls and a transaction-level memory model.
module tb_mem_port_arbiter;

  localparam int NREQ = 1000;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        busy;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .dm_err(dm_err), .busy(busy),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_araddr(m_araddr), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input bit dm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = dm ? dm_ack : if_ack;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // SLVERR / DECERR on selected address slots
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a[7:4] == 4'hE) return 2'b10;
    if (a[7:4] == 4'hD) return 2'b11;
    return 2'b00;
  endfunction

  task automatic slave_idle();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
  endtask

  logic [31:0] smem [logic [31:0]];
  bit          ar_f, aw_f, w_f, r_f, b_f, aw_h, w_h, rd_b, wr_b;
  int          rd_w, wr_w;
  logic [31:0] ar_a, aw_a, w_d;
  logic [3:0]  w_s;
  bit          pv_ar, pv_aw, pv_w;
  logic [31:0] pv_ara, pv_awa, pv_wd;
  logic [3:0]  pv_ws;

  // called once per falling edge; its choices take effect at the next rise
  task automatic slave_step();
    logic [31:0] old;
    logic [1:0]  rr;
    if (pv_ar && !ar_f)
      chk("ar_hold", {31'd0, m_arvalid, m_araddr}, {31'd0, 1'b1, pv_ara});
    if (pv_aw && !aw_f)
      chk("aw_hold", {31'd0, m_awvalid, m_awaddr}, {31'd0, 1'b1, pv_awa});
    if (pv_w && !w_f)
      chk("w_hold", {27'd0, m_wvalid, m_wstrb, m_wdata},
          {27'd0, 1'b1, pv_ws, pv_wd});
    if (r_f) m_rvalid = 1'b0;
    if (b_f) m_bvalid = 1'b0;
    if (ar_f) begin rd_b = 1'b1; rd_w = int'($urandom_range(0, 5)); end
    if (aw_f) aw_h = 1'b1;
    if (w_f) w_h = 1'b1;
    if (aw_h && w_h) begin
      aw_h = 1'b0; w_h = 1'b0; wr_b = 1'b1;
      wr_w = int'($urandom_range(0, 5));
      rr = resp_of(aw_a);
      if (!rr[1]) begin
        old = smem.exists(aw_a) ? smem[aw_a] : init_word(aw_a);
        for (int b = 0; b < 4; b++)
          if (w_s[b]) old[8*b +: 8] = w_d[8*b +: 8];
        smem[aw_a] = old;
      end
    end
    if (rd_b) begin
      if (rd_w == 0) begin
        rd_b = 1'b0; m_rvalid = 1'b1;
        m_rdata = smem.exists(ar_a) ? smem[ar_a] : init_word(ar_a);
        m_rresp = resp_of(ar_a);
      end else rd_w--;
    end
    if (wr_b) begin
      if (wr_w == 0) begin
        wr_b = 1'b0; m_bvalid = 1'b1; m_bresp = resp_of(aw_a);
      end else wr_w--;
    end
    m_arready = ($urandom_range(0, 1) == 0);
    m_awready = ($urandom_range(0, 1) == 0);
    m_wready  = ($urandom_range(0, 1) == 0);
    ar_f = m_arvalid && m_arready;
    aw_f = m_awvalid && m_awready;
    w_f  = m_wvalid && m_wready;
    if (ar_f) ar_a = m_araddr;
    if (aw_f) aw_a = m_awaddr;
    if (w_f) begin w_d = m_wdata; w_s = m_wstrb; end
    r_f = m_rvalid && m_rready;
    b_f = m_bvalid && m_bready;
    pv_ar = m_arvalid; pv_ara = m_araddr;
    pv_aw = m_awvalid; pv_awa = m_awaddr;
    pv_w  = m_wvalid;  pv_wd = m_wdata; pv_ws = m_wstrb;
  endtask

  logic [31:0] mmem [logic [31:0]];
  bit          f_act, d_act, d_isw, pf_ack, pd_ack, ok;
  logic [31:0] f_ed, d_ed, a, wd, mask, cur;
  logic        f_ee, d_ee;
  logic [3:0]  ws;
  logic [1:0]  rr;
  int          iss, fdone, ddone, nack, k;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    chk("reset_ctl", {54'd0, busy, if_ack, dm_ack, if_err, dm_err,
        m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 64'd0);
    chk("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
    chk("reset_addr", {m_araddr, m_awaddr}, 64'd0);
    chk("reset_wbeat", {28'd0, m_wstrb, m_wdata}, 64'd0);
    rst = 1'b1;

    // reset abandons an in-flight read address phase
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = m_arvalid;
    end
    chk("t1_arvalid_up", 64'(ok), 64'd1);
    #2 rst = 1'b0;
    #1 chk("t1_async_clear",
           {59'd0, m_arvalid, busy, if_ack, dm_ack, m_rready}, 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_idle_after", {62'd0, busy, m_arvalid}, 64'd0);

    // both requesters held: data wins until fetch has waited SMAX grants
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h11111111;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2100;
    nack = 0;
    for (int i = 0; i < 100 && nack < 10; i++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        chk("t4_one_ack", 64'(if_ack & dm_ack), 64'd0);
        chk($sformatf("t4_grant%0d_is_fetch", nack), 64'(if_ack),
            64'((nack % (SMAX + 1)) == SMAX));
        nack++;
      end
    end
    chk("t4_grant_count", 64'(nack), 64'd10);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_idle", 64'(busy), 64'd0);

    // zero-wait fetch: grant, arvalid, rready, ack on consecutive cycles
    m_rdata = 32'h00500093; m_rresp = 2'b00;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("t2_c1_arvalid", {30'd0, busy, m_arvalid, m_araddr},
        {30'd0, 1'b1, 1'b1, 32'h100});
    @(negedge clk);
    chk("t2_c2_rready", {62'd0, m_rready, m_arvalid}, 64'd2);
    @(negedge clk);
    chk("t2_c3_ack", {29'd0, if_ack, dm_ack, if_err, busy, if_rdata},
        {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00500093});
    if_addr = 32'h104;
    @(negedge clk);
    chk("t2_c4_no_grant", {61'd0, if_ack, m_arvalid, busy}, 64'd0);
    @(negedge clk);
    chk("t2_c5_regrant", {31'd0, m_arvalid, m_araddr},
        {31'd0, 1'b1, 32'h104});
    wait_ack("t2_second_ack", 1'b0);
    if_req = 1'b0;
    @(negedge clk);
    chk("t2_ack_pulse", 64'(if_ack), 64'd0);

    // write with W accepted two cycles before AW
    slave_idle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000;
    dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
    @(negedge clk);
    chk("t3_valids", {60'd0, m_awvalid, m_wvalid, m_arvalid, busy},
        64'b1101);
    chk("t3_payload", {m_awaddr, m_wdata}, {32'h2000, 32'hDEADBEEF});
    chk("t3_strb", 64'(m_wstrb), 64'hF);
    m_wready = 1'b1;
    @(negedge clk);
    chk("t3_w_done", {62'd0, m_awvalid, m_wvalid}, 64'b10);
    m_wready = 1'b0;
    @(negedge clk);
    chk("t3_aw_wait", {31'd0, m_awvalid, m_awaddr}, {31'd0, 1'b1, 32'h2000});
    m_awready = 1'b1;
    @(negedge clk);
    chk("t3_b_phase", {60'd0, m_awvalid, m_wvalid, m_bready, busy},
        64'b0011);
    m_awready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge clk);
    chk("t3_ack", {60'd0, dm_ack, dm_err, m_bready, busy}, 64'b1000);
    m_bvalid = 1'b0; dm_req = 1'b0;

    // error response completes normally, then a clean read follows
    m_arready = 1'b1; m_rvalid = 1'b1;
    m_rdata = 32'hCAFEF00D; m_rresp = 2'b10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    wait_ack("t5_err_ack", 1'b1);
    chk("t5_err_data", {31'd0, dm_err, dm_rdata}, {31'd0, 1'b1, 32'hCAFEF00D});
    m_rdata = 32'h12345678; m_rresp = 2'b00; dm_addr = 32'h3004;
    wait_ack("t5_next_ack", 1'b1);
    chk("t5_next_data", {31'd0, dm_err, dm_rdata}, {31'd0, 1'b0, 32'h12345678});
    dm_req = 1'b0;
    slave_idle();
    repeat (2) @(negedge clk);

    // random mixed traffic against the stalling slave
    iss = 0; fdone = 0; ddone = 0;
    f_act = 1'b0; d_act = 1'b0; d_isw = 1'b0; pf_ack = 1'b0; pd_ack = 1'b0;
    f_ed = '0; d_ed = '0; f_ee = 1'b0; d_ee = 1'b0;
    for (int cyc = 0; cyc < 60000 && (fdone + ddone) < NREQ; cyc++) begin
      @(negedge clk);
      slave_step();
      if (pf_ack) chk("rnd_if_pulse", 64'(if_ack), 64'd0);
      if (pd_ack) chk("rnd_dm_pulse", 64'(dm_ack), 64'd0);
      pf_ack = if_ack; pd_ack = dm_ack;
      if (if_ack) begin
        chk("rnd_if_owner", 64'(f_act), 64'd1);
        chk("rnd_if_rdata", {31'd0, if_err, if_rdata}, {31'd0, f_ee, f_ed});
        f_act = 1'b0; if_req = 1'b0; fdone++;
      end
      if (dm_ack) begin
        chk("rnd_dm_owner", 64'(d_act), 64'd1);
        if (d_isw) chk("rnd_dm_werr", 64'(dm_err), 64'(d_ee));
        else chk("rnd_dm_rdata", {31'd0, dm_err, dm_rdata},
                 {31'd0, d_ee, d_ed});
        d_act = 1'b0; dm_req = 1'b0; ddone++;
      end
      if (!f_act && iss < NREQ && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 63));
        a = 32'h100 + 32'(k) * 4;
        rr = resp_of(a);
        f_ed = init_word(a); f_ee = rr[1];
        if_addr = a; if_req = 1'b1; f_act = 1'b1; iss++;
      end
      if (!d_act && iss < NREQ && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 63));
        a = 32'h2000 + 32'(k) * 4;
        rr = resp_of(a);
        d_ee = rr[1];
        d_isw = ($urandom_range(0, 1) == 1);
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        cur = mmem.exists(a) ? mmem[a] : init_word(a);
        if (d_isw) begin
          mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
          if (!d_ee) mmem[a] = (cur & ~mask) | (wd & mask);
        end else begin
          d_ed = cur;
        end
        dm_addr = a; dm_we = d_isw; dm_wdata = wd; dm_wstrb = ws;
        dm_req = 1'b1; d_act = 1'b1; iss++;
      end
    end
    chk("rnd_all_done", 64'(fdone + ddone), 64'(NREQ));
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
